// File: rtl/axi_req_dispatcher_pkg.sv
// Shared types for the request dispatcher: FSM encoding, the registered request
// record and the packed read-completion context held in the in-order FIFO.
package axi_req_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b001,
      ST_RD_ISSUE = 3'b010,
      ST_WR_ISSUE = 3'b100
   } disp_state_e;

   typedef struct packed {
      logic [2:0]  bar_hit;
      logic [31:0] pcie_address;
      logic [3:0]  byte_enable;
      logic        write_readn;
      logic        phys_func;
      logic [31:0] write_data;
      logic [7:0]  tag;
      logic [15:0] id;
   } req_fields_t;

   // Field order fixes the 36-bit layout: tag in the MSBs, function in bit 0.
   typedef struct packed {
      logic [7:0]  tag;
      logic [15:0] id;
      logic [6:0]  lower_addr;
      logic [3:0]  byte_enable;
      logic        phys_func;
   } rd_ctx_t;

   localparam int CTX_W      = $bits(rd_ctx_t);
   localparam int DW_SEL_BIT = 2;

   function automatic logic [31:0] dword_select(input logic [63:0] qword, input logic upper);
      if (upper) begin
         dword_select = qword[63:32];
      end else begin
         dword_select = qword[31:0];
      end
   endfunction

endpackage

// File: rtl/axi_req_dispatcher_if.sv
// Bundle between the request decoder, the AXI-Lite read/write controllers and the
// completion generator; master is the dispatcher side, slave the surrounding logic.
interface axi_req_dispatcher_if #(
   parameter int CPLD_DATA_WIDTH = 64,
   parameter int CNT_W           = 3
);
   logic                       req_valid;
   logic                       req_ready;
   logic [2:0]                 req_bar_hit;
   logic [31:0]                req_pcie_address;
   logic [3:0]                 req_byte_enable;
   logic                       req_write_readn;
   logic                       req_phys_func;
   logic [31:0]                req_write_data;
   logic [7:0]                 req_tag;
   logic [15:0]                req_id;

   logic [2:0]                 mem_req_bar_hit;
   logic [31:0]                mem_req_pcie_address;
   logic [3:0]                 mem_req_byte_enable;
   logic                       mem_req_write_readn;
   logic                       mem_req_phys_func;
   logic [31:0]                mem_req_write_data;
   logic                       rd_req_valid;
   logic                       rd_req_ready;
   logic                       wr_req_valid;
   logic                       wr_req_ready;

   logic                       rd_cpld_valid;
   logic                       rd_cpld_ready;
   logic [CPLD_DATA_WIDTH-1:0] rd_cpld_data;
   logic                       cpl_valid;
   logic                       cpl_ready;
   logic [31:0]                cpl_data;
   logic [7:0]                 cpl_tag;
   logic [15:0]                cpl_id;
   logic [6:0]                 cpl_lower_addr;
   logic [3:0]                 cpl_byte_enable;
   logic                       cpl_phys_func;
   logic [CNT_W-1:0]           outstanding_count;
   logic                       err_orphan_cpl;

   modport master (
      input  req_valid, req_bar_hit, req_pcie_address, req_byte_enable,
             req_write_readn, req_phys_func, req_write_data, req_tag, req_id,
             rd_req_ready, wr_req_ready, rd_cpld_valid, rd_cpld_data, cpl_ready,
      output req_ready, mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
             mem_req_write_readn, mem_req_phys_func, mem_req_write_data,
             rd_req_valid, wr_req_valid, rd_cpld_ready, cpl_valid, cpl_data,
             cpl_tag, cpl_id, cpl_lower_addr, cpl_byte_enable, cpl_phys_func,
             outstanding_count, err_orphan_cpl
   );

   modport slave (
      output req_valid, req_bar_hit, req_pcie_address, req_byte_enable,
             req_write_readn, req_phys_func, req_write_data, req_tag, req_id,
             rd_req_ready, wr_req_ready, rd_cpld_valid, rd_cpld_data, cpl_ready,
      input  req_ready, mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
             mem_req_write_readn, mem_req_phys_func, mem_req_write_data,
             rd_req_valid, wr_req_valid, rd_cpld_ready, cpl_valid, cpl_data,
             cpl_tag, cpl_id, cpl_lower_addr, cpl_byte_enable, cpl_phys_func,
             outstanding_count, err_orphan_cpl
   );
endinterface

// File: rtl/axi_req_dispatcher_rd_ctx_fifo.sv
// In-order context FIFO for outstanding reads; depth need not be a power of two,
// so pointers wrap explicitly at DEPTH-1.
module rd_ctx_fifo #(
   parameter int  WIDTH = 36,
   parameter int  DEPTH = 5,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = ptr + PTR_W'(1);
      end
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // A push into a full FIFO is only honoured when a pop frees the head slot.
   always_comb begin
      pop_ok_s  = pop_i & ~empty_o;
      push_ok_s = push_i & (~full_o | pop_ok_s);
      wr_ptr_d  = push_ok_s ? ptr_next(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop_ok_s ? ptr_next(rd_ptr_q) : rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/axi_req_dispatcher.sv
// Steers decoded PCIe memory requests to the AXI-Lite read or write controller and
// re-attaches stored read context to each returning data beat.
module axi_req_dispatcher
   import axi_req_dispatcher_pkg::*;
#(
   parameter int OUTSTANDING_READS = 5,
   parameter int CPLD_DATA_WIDTH   = 64
) (
   input  logic                  m_axi_aclk,
   input  logic                  m_axi_areset,
   axi_req_dispatcher_if.master  bus_if
);
   localparam int CNT_W = $clog2(OUTSTANDING_READS + 1);

   disp_state_e      state_q, state_d;
   req_fields_t      req_q, req_d;
   logic             req_ready_s;
   logic             push_s, pop_s;
   logic             fifo_full_s, fifo_empty_s;
   logic [CNT_W-1:0] fifo_count_s;
   rd_ctx_t          push_ctx_s, head_ctx_s;
   logic             err_orphan_q, err_orphan_d;
   logic [31:0]      cpl_dword_s;

   // Request acceptance is combinational and masked during reset so nothing handshakes then.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      req_ready_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_s = bus_if.req_valid & ~m_axi_areset &
                          (bus_if.req_write_readn | ~fifo_full_s);
            if (req_ready_s) begin
               req_d.bar_hit      = bus_if.req_bar_hit;
               req_d.pcie_address = bus_if.req_pcie_address;
               req_d.byte_enable  = bus_if.req_byte_enable;
               req_d.write_readn  = bus_if.req_write_readn;
               req_d.phys_func    = bus_if.req_phys_func;
               req_d.write_data   = bus_if.req_write_data;
               req_d.tag          = bus_if.req_tag;
               req_d.id           = bus_if.req_id;
               state_d = bus_if.req_write_readn ? ST_WR_ISSUE : ST_RD_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_ISSUE: begin
            if (bus_if.rd_req_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_ISSUE;
            end
         end
         ST_WR_ISSUE: begin
            if (bus_if.wr_req_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WR_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Context is pushed only when the read controller takes the request.
   always_comb begin
      push_ctx_s.tag         = req_q.tag;
      push_ctx_s.id          = req_q.id;
      push_ctx_s.lower_addr  = req_q.pcie_address[6:0];
      push_ctx_s.byte_enable = req_q.byte_enable;
      push_ctx_s.phys_func   = req_q.phys_func;
      push_s       = (state_q == ST_RD_ISSUE) & bus_if.rd_req_ready;
      pop_s        = bus_if.rd_cpld_valid & bus_if.cpl_ready & ~fifo_empty_s;
      err_orphan_d = err_orphan_q | (bus_if.rd_cpld_valid & fifo_empty_s);
   end

   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   rd_ctx_fifo #(
      .WIDTH (CTX_W),
      .DEPTH (OUTSTANDING_READS)
   ) u_rd_ctx_fifo (
      .clk_i   (m_axi_aclk),
      .rst_i   (m_axi_areset),
      .push_i  (push_s),
      .din_i   (push_ctx_s),
      .pop_i   (pop_s),
      .dout_o  (head_ctx_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   generate
      if (CPLD_DATA_WIDTH >= 64) begin : g_dw_sel
         assign cpl_dword_s = dword_select(bus_if.rd_cpld_data[63:0],
                                           head_ctx_s.lower_addr[DW_SEL_BIT]);
      end else begin : g_dw_fixed
         assign cpl_dword_s = bus_if.rd_cpld_data[31:0];
      end
   endgenerate

   assign bus_if.req_ready            = req_ready_s;
   assign bus_if.mem_req_bar_hit      = req_q.bar_hit;
   assign bus_if.mem_req_pcie_address = req_q.pcie_address;
   assign bus_if.mem_req_byte_enable  = req_q.byte_enable;
   assign bus_if.mem_req_write_readn  = req_q.write_readn;
   assign bus_if.mem_req_phys_func    = req_q.phys_func;
   assign bus_if.mem_req_write_data   = req_q.write_data;
   assign bus_if.rd_req_valid         = (state_q == ST_RD_ISSUE);
   assign bus_if.wr_req_valid         = (state_q == ST_WR_ISSUE);

   assign bus_if.cpl_valid            = bus_if.rd_cpld_valid & ~fifo_empty_s;
   assign bus_if.rd_cpld_ready        = bus_if.cpl_ready & ~fifo_empty_s;
   assign bus_if.cpl_data             = cpl_dword_s;
   assign bus_if.cpl_tag              = head_ctx_s.tag;
   assign bus_if.cpl_id               = head_ctx_s.id;
   assign bus_if.cpl_lower_addr       = head_ctx_s.lower_addr;
   assign bus_if.cpl_byte_enable      = head_ctx_s.byte_enable;
   assign bus_if.cpl_phys_func        = head_ctx_s.phys_func;
   assign bus_if.outstanding_count    = fifo_count_s;
   assign bus_if.err_orphan_cpl       = err_orphan_q;

endmodule

// File: doc/axi_req_dispatcher.md
Name: axi_req_dispatcher

Overview:
- Sits between the PCIe RX request decoder and the AXI-Lite read and write controllers of the PCIe-to-AXI-Lite bridge.
- Accepts one decoded memory request at a time and steers it to the read or write controller.
- Stores per-read completion context (tag, requester ID, lower address, byte enables) in an in-order FIFO, bounded by OUTSTANDING_READS.
- Re-attaches that context to each read data beat returning from the read controller, for the completion TLP generator.

Parameters:
- OUTSTANDING_READS, 5, maximum number of issued reads whose data has not yet returned; also the context FIFO depth (≥1).
- CPLD_DATA_WIDTH, 64, width of the read data returned by the read controller.
- TCQ, 1, simulation clock-to-q delay on registered assignments.

Ports:
m_axi_aclk  in  1  single clock for all logic
m_axi_areset  in  1  asynchronous, active-high reset
req_valid  in  1  decoded request valid
req_ready  out  1  request accepted this cycle
req_bar_hit  in  3  BAR index
req_pcie_address  in  32  PCIe byte address
req_byte_enable  in  4  first-DW byte enables
req_write_readn  in  1  1=write, 0=read
req_phys_func  in  1  physical function
req_write_data  in  32  write payload
req_tag  in  8  TLP tag
req_id  in  16  requester ID
mem_req_bar_hit/pcie_address/byte_enable/write_readn/phys_func/write_data  out  3/32/4/1/1/32  registered copy of the request, shared by both controllers
rd_req_valid  out  1  request valid to read controller
rd_req_ready  in  1  read controller ready
wr_req_valid  out  1  request valid to write controller
wr_req_ready  in  1  write controller ready
rd_cpld_valid  in  1  read data valid from read controller
rd_cpld_ready  out  1  read data accepted
rd_cpld_data  in  CPLD_DATA_WIDTH  read data
cpl_valid  out  1  completion valid
cpl_ready  in  1  completion generator ready
cpl_data  out  32  selected DWORD
cpl_tag  out  8  context tag
cpl_id  out  16  context requester ID
cpl_lower_addr  out  7  context address[6:0]
cpl_byte_enable  out  4  context byte enables
cpl_phys_func  out  1  context function
outstanding_count  out  $clog2(OUTSTANDING_READS+1)  FIFO occupancy
err_orphan_cpl  out  1  sticky flag: read data arrived with no context held

Behaviour:
- Reset (async assert, sync deassert usage):
  - state=IDLE; FIFO emptied; count=0.
  - All valids low; req_ready=0; err_orphan_cpl=0; mem_req_* fields=0.
- Reset mid-operation drops the in-flight request and all stored contexts; no handshake completes in the reset cycle.
- FSM states IDLE, RD_ISSUE, WR_ISSUE (one-hot, localparams).
- IDLE:
  - req_ready = req_valid & (req_write_readn | count<OUTSTANDING_READS). Combinational; the decoder holds fields stable while valid.
  - On acceptance, capture all fields into mem_req_* next cycle. Go to WR_ISSUE with wr_req_valid=1, or RD_ISSUE with rd_req_valid=1.
  - A read with the FIFO full waits in IDLE, req_ready low.
- RD_ISSUE: hold rd_req_valid until rd_req_ready. On that handshake:
  - push {tag,id,addr[6:0],byte_enable,phys_func} into the FIFO;
  - drop valid; return to IDLE.
- WR_ISSUE: hold wr_req_valid until wr_req_ready; then drop valid and return to IDLE. Writes never touch the FIFO.
- Throughput and latency:
  - Minimum 2 cycles per request.
  - Accept-to-controller-valid latency is 1 cycle.
  - Writes may be dispatched while reads are outstanding (posted writes may pass reads).
- Completion path, combinational:
  - cpl_valid = rd_cpld_valid & !empty.
  - rd_cpld_ready = cpl_ready & !empty.
  - cpl_* context comes from the FIFO head.
  - cpl_data = rd_cpld_data[63:32] if head addr[2]=1, else [31:0]. For CPLD_DATA_WIDTH=32, always [31:0].
  - Pop on rd_cpld_valid & cpl_ready & !empty.
- Orphan data: rd_cpld_valid while empty holds rd_cpld_ready low and sets err_orphan_cpl, which stays set until reset.
- Occupancy: push and pop in the same cycle leave count unchanged. Pointers wrap modulo OUTSTANDING_READS, which need not be a power of two. count never exceeds OUTSTANDING_READS.

Decomposition:
- Shared include file (axi_bridge_defs.vh):
  - FSM state localparams;
  - context field widths and offsets (CTX_W=36);
  - DWORD-select bit index.
- Sub-module rd_ctx_fifo:
  - synchronous FIFO, parameters WIDTH=CTX_W and DEPTH=OUTSTANDING_READS;
  - push/pop/full/empty/count;
  - async active-high reset.

Test Plan:
- Reset, then a single read (tag 0x12, id 0xABCD, addr 0x0000_0104, be 0xF) with rd_cpld_data 0x11112222_33334444 → rd_req_valid 1 cycle after acceptance; cpl_data=0x11112222, cpl_tag=0x12, cpl_lower_addr=0x04; count 1→0.
- 5 reads with no data returned, then a 6th read → req_ready stays 0 for the 6th. A write offered afterwards is accepted and wr_req_valid asserts; count stays 5.
- Return 5 data beats with cpl_ready toggling 1,0,1 → completions leave in issue order (tags 0..4); no beat is lost or duplicated while cpl_ready=0.
- Push and pop in the same cycle at count=3 → count stays 3; FIFO pointer wraps correctly at depth 5.
- rd_cpld_valid=1 with the FIFO empty → rd_cpld_ready=0, cpl_valid=0, err_orphan_cpl=1 until reset.
- Assert m_axi_areset while in RD_ISSUE with 2 reads outstanding → next edge: all valids 0, count 0, state IDLE, err flag cleared.
